persp_projector_pipe: RTL and testbench
=======================================

// Module: persp_projector_pipe
// PURPOSE
//  Parametrised perspective/orthographic vertex projector for the transformer stage.
//  Accepts camera-space vertices and computes x' = f*x/z + cx, y' = f*y/z + cy.
//  Projection uses an internal iterative divider and a single-cycle multiply.
//  Adds a near-plane clip flag, saturation/overflow flag, a viewport offset,
//  and an OUT_DEPTH output FIFO so the rasteriser can back-pressure without stalling the divider.
// PARAMETERS
//  WIDTH      32  signed fixed-point word width of all coordinates
//  FBITS      16  fractional bits (Q(WIDTH-FBITS).FBITS)
//  COLOR_W    16  colour payload width (passed through untouched)
//  OUT_DEPTH  4   output FIFO entries (power of two, >=2)
// PORTS
//  clk        in   1        clock
//  rst        in   1        asynchronous active-high reset
//  in_x/in_y/in_z in WIDTH  signed camera-space vertex
//  in_color   in   COLOR_W  payload
//  in_valid   in   1        input handshake
//  in_ready   out  1        high only in IDLE
//  mode       in   1        0 = perspective, 1 = orthographic (scale = focal)
//  focal      in   WIDTH    focal length, unsigned fixed-point
//  near_z     in   WIDTH    near-plane magnitude, unsigned fixed-point
//  cx/cy      in   WIDTH    signed viewport offset
//  out_x/out_y/out_z out WIDTH  projected vertex (out_z = in_z)
//  out_color  out  COLOR_W  payload
//  out_clip   out  1        |z| < near_z
//  out_ovf    out  1        scale or result saturated
//  out_valid  out  1        FIFO head valid (first-word fall-through)
//  out_ready  in   1        pops head when out_valid && out_ready
//  busy       out  1        state != IDLE || FIFO not empty
// BEHAVIOUR
//  Reset (async, any state): state=IDLE, FIFO emptied, any divide aborted; out_valid=0,
//    out_clip=0, out_ovf=0, out_x/out_y/out_z/out_color=0, in_ready=1, busy=0.
//  Accept on edge T when in_valid && in_ready.
//    Vertex, mode, focal, near_z, cx and cy are latched; later changes to them do not affect this vertex.
//  FSM transitions:
//    IDLE -accept-> DIV (perspective, not clipped)
//    IDLE -accept-> MUL (ortho or clipped)
//    DIV -(WIDTH+FBITS cycles)-> MUL -> PUSH
//    PUSH -FIFO not full-> IDLE
//    PUSH holds while FIFO full
//  DIV: restoring unsigned divide, one quotient bit per cycle.
//    Quotient = (focal<<FBITS)/|z|, WIDTH+FBITS bits.
//    If quotient > 2^(WIDTH-1)-1, scale saturates to that maximum and ovf is set.
//  Clip: |z| < near_z (z==0 always clipped).
//    out_clip=1, out_x=cx, out_y=cy, DIV skipped.
//  MUL: p = x*scale (2*WIDTH signed), arithmetic shift right by FBITS.
//    Negate when z<0 (perspective only); then add cx (or cy).
//    Saturate to the signed WIDTH range and set ovf when clamped. Same for y.
//  PUSH writes the FIFO; out_valid rises after that edge.
//  Latency, empty FIFO, accept edge T to out_valid high:
//    perspective: edge T+WIDTH+FBITS+2
//    ortho/clip:  edge T+2
//  FIFO order: strict FIFO order.
//    Simultaneous push and pop when full is allowed: the PUSH completes.
//    out_* are stable while out_valid && !out_ready.
//  Only one vertex is in flight in the FSM; throughput = 1 per (latency+1) cycles.
// TESTING
//  (Q16.16, defaults.)
//  Persp: f=0x00010000, x=0x00020000, y=0, z=0x00040000, near=0x100, cx=cy=0
//    -> out_x=0x00008000, out_y=0, clip=0, ovf=0; out_valid at T+50.
//  Negative z: same with z=0xFFFC0000 -> out_x=0xFFFF8000.
//  Clip: z=0x00000100, near=0x00001000, cx=0x01400000
//    -> out_clip=1, out_x=0x01400000; out_valid at T+2.
//  Ortho: mode=1, f=0x00020000, x=0x00030000, cx=0x01400000
//    -> out_x=0x01460000; out_valid at T+2.
//  Overflow: f=0x7FFF0000, z=0x00000001, near=1, x=0x00010000
//    -> out_ovf=1, out_x=0x7FFFFFFF.
//  Backpressure: out_ready=0, 6 vertices offered
//    -> 4 queued, 5th holds in PUSH, in_ready=0.
//    Release out_ready -> all 6 delivered in order.
//  Reset mid-DIV: assert rst at T+10
//    -> out_valid=0, in_ready=1 immediately.
//    The next vertex projects correctly.

Source files
------------

// File: rtl/persp_projector_pipe_if.sv
// Vertex-in / projected-vertex-out bundle for persp_projector_pipe.
// The slave modport is the projector; the master modport is the driving stage / rasteriser.
interface persp_projector_pipe_if #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned COLOR_W = 16
);
    logic signed [WIDTH-1:0] in_x;
    logic signed [WIDTH-1:0] in_y;
    logic signed [WIDTH-1:0] in_z;
    logic [COLOR_W-1:0]      in_color;
    logic                    in_valid;
    logic                    in_ready;
    logic                    mode;
    logic [WIDTH-1:0]        focal;
    logic [WIDTH-1:0]        near_z;
    logic signed [WIDTH-1:0] cx;
    logic signed [WIDTH-1:0] cy;

    logic signed [WIDTH-1:0] out_x;
    logic signed [WIDTH-1:0] out_y;
    logic signed [WIDTH-1:0] out_z;
    logic [COLOR_W-1:0]      out_color;
    logic                    out_clip;
    logic                    out_ovf;
    logic                    out_valid;
    logic                    out_ready;
    logic                    busy;

    modport master (
        output in_x, in_y, in_z, in_color, in_valid, mode, focal, near_z, cx, cy, out_ready,
        input  in_ready, out_x, out_y, out_z, out_color, out_clip, out_ovf, out_valid, busy
    );

    modport slave (
        input  in_x, in_y, in_z, in_color, in_valid, mode, focal, near_z, cx, cy, out_ready,
        output in_ready, out_x, out_y, out_z, out_color, out_clip, out_ovf, out_valid, busy
    );
endinterface

// File: rtl/persp_projector_pipe.sv
// Perspective/orthographic vertex projector: x' = f*x/z + cx, y' = f*y/z + cy.
// Iterative restoring divider for f/|z|, one-cycle multiply, first-word fall-through output FIFO.
module persp_projector_pipe #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned FBITS     = 16,
    parameter int unsigned COLOR_W   = 16,
    parameter int unsigned OUT_DEPTH = 4
) (
    input logic                   clk,
    input logic                   rst,
    persp_projector_pipe_if.slave bus
);

    localparam int unsigned QW    = WIDTH + FBITS;
    localparam int unsigned CW    = $clog2(QW);
    localparam int unsigned PW    = 2 * WIDTH + 2;
    localparam int unsigned AW    = $clog2(OUT_DEPTH);
    localparam int unsigned EW    = 3 * WIDTH + COLOR_W + 2;
    localparam int unsigned X_LSB = COLOR_W + 2;
    localparam int unsigned Y_LSB = X_LSB + WIDTH;
    localparam int unsigned Z_LSB = Y_LSB + WIDTH;

    localparam logic signed [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic signed [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {StIdle, StDiv, StMul, StPush} state_e;

    state_e state_q, state_d;

    logic signed [WIDTH-1:0] x_q, y_q, z_q, cx_q, cy_q;
    logic [COLOR_W-1:0]      color_q;
    logic [WIDTH-1:0]        focal_q, divisor_q, rem_q;
    logic [QW-1:0]           dq_q;
    logic [CW-1:0]           cnt_q;
    logic                    mode_q, neg_q, clip_q;
    logic signed [WIDTH-1:0] res_x_q, res_y_q;
    logic                    res_ovf_q;

    logic                    accept, clip_in, div_last, div_ge;
    logic [WIDTH-1:0]        abs_z_in, rem_next;
    logic [WIDTH:0]          rem_shift;
    logic [QW-1:0]           dq_next;
    logic signed [WIDTH-1:0] scale;
    logic                    scale_ovf;
    logic [WIDTH:0]          map_x, map_y;

    logic [EW-1:0]           mem_q [OUT_DEPTH];
    logic [AW:0]             wr_ptr_q, rd_ptr_q;
    logic                    empty, full, push, pop;
    logic [EW-1:0]           entry, head;

    // Returns {ovf, value}: (v*s >>> FBITS), optionally negated, plus offset, clamped to WIDTH.
    function automatic logic [WIDTH:0] map_coord(input logic signed [WIDTH-1:0] v,
                                                 input logic signed [WIDTH-1:0] s,
                                                 input logic                    negate,
                                                 input logic signed [WIDTH-1:0] off);
        logic signed [PW-1:0] acc;
        acc = PW'(v) * PW'(s);
        acc = acc >>> FBITS;
        if (negate) acc = -acc;
        acc = acc + PW'(off);
        if (acc > PW'(SMAX)) return {1'b1, SMAX};
        if (acc < PW'(SMIN)) return {1'b1, SMIN};
        return {1'b0, acc[WIDTH-1:0]};
    endfunction

    assign accept   = bus.in_valid && (state_q == StIdle);
    assign abs_z_in = bus.in_z[WIDTH-1] ? -bus.in_z : bus.in_z;
    assign clip_in  = (bus.in_z == '0) || (abs_z_in < bus.near_z);

    // Restoring divide step; the remainder always stays below the divisor, so WIDTH bits suffice.
    assign rem_shift = {rem_q, dq_q[QW-1]};
    assign div_ge    = rem_shift >= {1'b0, divisor_q};
    assign rem_next  = div_ge ? rem_shift[WIDTH-1:0] - divisor_q : rem_shift[WIDTH-1:0];
    assign dq_next   = {dq_q[QW-2:0], div_ge};
    assign div_last  = cnt_q == CW'(QW - 1);

    always_comb begin
        scale     = SMAX;
        scale_ovf = 1'b0;
        if (mode_q) begin
            scale_ovf = focal_q[WIDTH-1];
            scale     = scale_ovf ? SMAX : $signed(focal_q);
        end else begin
            scale_ovf = |dq_q[QW-1:WIDTH-1];
            scale     = scale_ovf ? SMAX : $signed(dq_q[WIDTH-1:0]);
        end
        map_x = map_coord(x_q, scale, neg_q && !mode_q, cx_q);
        map_y = map_coord(y_q, scale, neg_q && !mode_q, cy_q);
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (accept) state_d = (bus.mode || clip_in) ? StMul : StDiv;
            StDiv:  if (div_last) state_d = StMul;
            StMul:  state_d = StPush;
            StPush: if (push) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= StIdle;
        else     state_q <= state_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_q       <= '0;
            y_q       <= '0;
            z_q       <= '0;
            cx_q      <= '0;
            cy_q      <= '0;
            color_q   <= '0;
            focal_q   <= '0;
            divisor_q <= '0;
            rem_q     <= '0;
            dq_q      <= '0;
            cnt_q     <= '0;
            mode_q    <= 1'b0;
            neg_q     <= 1'b0;
            clip_q    <= 1'b0;
            res_x_q   <= '0;
            res_y_q   <= '0;
            res_ovf_q <= 1'b0;
        end else begin
            if (accept) begin
                x_q       <= bus.in_x;
                y_q       <= bus.in_y;
                z_q       <= bus.in_z;
                cx_q      <= bus.cx;
                cy_q      <= bus.cy;
                color_q   <= bus.in_color;
                focal_q   <= bus.focal;
                divisor_q <= abs_z_in;
                rem_q     <= '0;
                dq_q      <= {bus.focal, {FBITS{1'b0}}};
                cnt_q     <= '0;
                mode_q    <= bus.mode;
                neg_q     <= bus.in_z[WIDTH-1];
                clip_q    <= clip_in;
            end
            if (state_q == StDiv) begin
                rem_q <= rem_next;
                dq_q  <= dq_next;
                cnt_q <= cnt_q + CW'(1);
            end
            if (state_q == StMul) begin
                if (clip_q) begin
                    res_x_q   <= cx_q;
                    res_y_q   <= cy_q;
                    res_ovf_q <= 1'b0;
                end else begin
                    res_x_q   <= map_x[WIDTH-1:0];
                    res_y_q   <= map_y[WIDTH-1:0];
                    res_ovf_q <= scale_ovf | map_x[WIDTH] | map_y[WIDTH];
                end
            end
        end
    end

    // Output FIFO; a push into a full FIFO is allowed when the head pops on the same edge.
    assign empty = wr_ptr_q == rd_ptr_q;
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign pop   = !empty && bus.out_ready;
    assign push  = (state_q == StPush) && (!full || pop);
    assign entry = {z_q, res_y_q, res_x_q, color_q, clip_q, res_ovf_q};
    assign head  = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int unsigned i = 0; i < OUT_DEPTH; i++) mem_q[i] <= '0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q[AW-1:0]] <= entry;
                wr_ptr_q                <= wr_ptr_q + (AW+1)'(1);
            end
            if (pop) rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
        end
    end

    assign bus.in_ready  = state_q == StIdle;
    assign bus.busy      = (state_q != StIdle) || !empty;
    assign bus.out_valid = !empty;
    assign bus.out_x     = empty ? '0 : head[X_LSB +: WIDTH];
    assign bus.out_y     = empty ? '0 : head[Y_LSB +: WIDTH];
    assign bus.out_z     = empty ? '0 : head[Z_LSB +: WIDTH];
    assign bus.out_color = empty ? '0 : head[2 +: COLOR_W];
    assign bus.out_clip  = !empty && head[1];
    assign bus.out_ovf   = !empty && head[0];

endmodule

// File: tb/tb_persp_projector_pipe.sv
// Self-checking bench for persp_projector_pipe: directed cases, backpressure, reset abort,
// and random vertices against an arithmetic reference model.
module tb_persp_projector_pipe;

    typedef struct {
        logic signed [31:0] x, y, z;
        logic [15:0]        color;
        logic               mode;
        logic [31:0]        focal, near_z;
        logic signed [31:0] cx, cy;
    } vtx_t;

    typedef struct {
        logic [31:0] x, y, z;
        logic [15:0] color;
        logic        clip, ovf;
        int          lat;
    } res_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    persp_projector_pipe_if #(.WIDTH(32), .COLOR_W(16)) bus ();

    persp_projector_pipe #(
        .WIDTH(32), .FBITS(16), .COLOR_W(16), .OUT_DEPTH(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // Reference: plain 64-bit arithmetic straight from the projection equations.
    function automatic res_t model(input vtx_t v);
        res_t   r;
        longint az, scale, p;
        longint maxv = 64'sd2147483647;
        longint minv = -64'sd2147483648;
        longint off [2];
        longint c [2];
        r.z = v.z; r.color = v.color; r.ovf = 1'b0;
        az = (v.z < 0) ? -longint'(v.z) : longint'(v.z);
        r.clip = (v.z == 0) || (az < longint'(v.near_z));
        r.lat = (v.mode || r.clip) ? 2 : 50;
        if (r.clip) begin
            r.x = v.cx; r.y = v.cy;
            return r;
        end
        scale = v.mode ? longint'(v.focal) : (longint'(v.focal) * 65536) / az;
        if (scale > maxv) begin scale = maxv; r.ovf = 1'b1; end
        off[0] = longint'(v.cx); off[1] = longint'(v.cy);
        c[0] = longint'(v.x);    c[1] = longint'(v.y);
        for (int k = 0; k < 2; k++) begin
            p = (c[k] * scale) >>> 16;
            if (!v.mode && v.z < 0) p = -p;
            p = p + off[k];
            if (p > maxv) begin p = maxv; r.ovf = 1'b1; end
            if (p < minv) begin p = minv; r.ovf = 1'b1; end
            if (k == 0) r.x = p[31:0]; else r.y = p[31:0];
        end
        return r;
    endfunction

    function automatic vtx_t mk(input logic signed [31:0] x, y, z, input logic m,
                                input logic [31:0] f, nz, input logic signed [31:0] cx, cy);
        vtx_t v;
        v.x = x; v.y = y; v.z = z; v.mode = m; v.focal = f; v.near_z = nz;
        v.cx = cx; v.cy = cy; v.color = 16'($urandom);
        return v;
    endfunction

    task automatic send(input vtx_t v, output int t_acc);
        int n = 0;
        bus.in_x = v.x; bus.in_y = v.y; bus.in_z = v.z; bus.in_color = v.color;
        bus.mode = v.mode; bus.focal = v.focal; bus.near_z = v.near_z;
        bus.cx = v.cx; bus.cy = v.cy; bus.in_valid = 1'b1;
        while (!bus.in_ready && n < 400) begin @(posedge clk); #1; n++; end
        if (!bus.in_ready) begin
            checks++; errors++;
            $display("FAIL send_timeout: in_ready=%b required 1", bus.in_ready);
        end
        @(posedge clk); #1;
        t_acc = cyc;
        bus.in_valid = 1'b0;
        // Scramble inputs so a design that fails to latch them shows it.
        bus.in_x = $urandom; bus.in_y = $urandom; bus.in_z = $urandom;
        bus.focal = $urandom; bus.cx = $urandom; bus.cy = $urandom; bus.mode = ~bus.mode;
    endtask

    // Waits for a head entry, captures it, then lets one edge pass so it pops (out_ready=1).
    task automatic wait_out(output res_t o);
        int n = 0;
        while (!bus.out_valid && n < 400) begin @(posedge clk); #1; n++; end
        if (!bus.out_valid) begin
            checks++; errors++;
            $display("FAIL out_timeout: out_valid=%b required 1", bus.out_valid);
        end
        o.x = bus.out_x; o.y = bus.out_y; o.z = bus.out_z; o.color = bus.out_color;
        o.clip = bus.out_clip; o.ovf = bus.out_ovf; o.lat = cyc;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #12;
        checks += 6;
        if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", bus.out_valid); end
        if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", bus.in_ready); end
        if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        if (bus.out_x !== 32'h0) begin errors++; $display("FAIL reset_out_x: got %h want 0", bus.out_x); end
        if (bus.out_clip !== 1'b0) begin errors++; $display("FAIL reset_clip: got %b want 0", bus.out_clip); end
        if (bus.out_ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b want 0", bus.out_ovf); end
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        vtx_t  v [5];
        logic [31:0] wx [5];
        logic  wclip [5];
        logic  wovf [5];
        int    wlat [5];
        string nm [5];
        int    t;
        res_t  o;
        v[0] = mk(32'h0002_0000, 0, 32'h0004_0000, 0, 32'h0001_0000, 32'h100, 0, 0);
        v[1] = mk(32'h0002_0000, 0, 32'hFFFC_0000, 0, 32'h0001_0000, 32'h100, 0, 0);
        v[2] = mk(32'h0002_0000, 0, 32'h0000_0100, 0, 32'h0001_0000, 32'h1000, 32'h0140_0000, 0);
        v[3] = mk(32'h0003_0000, 0, 32'h0004_0000, 1, 32'h0002_0000, 32'h100, 32'h0140_0000, 0);
        v[4] = mk(32'h0001_0000, 0, 32'h0000_0001, 0, 32'h7FFF_0000, 32'h1, 0, 0);
        wx = '{32'h0000_8000, 32'hFFFF_8000, 32'h0140_0000, 32'h0146_0000, 32'h7FFF_FFFF};
        wclip = '{0, 0, 1, 0, 0};
        wovf = '{0, 0, 0, 0, 1};
        wlat = '{50, 50, 2, 2, 50};
        nm = '{"persp", "neg_z", "clip", "ortho", "overflow"};
        for (int i = 0; i < 5; i++) begin
            send(v[i], t);
            wait_out(o);
            checks += 6;
            if (o.x !== wx[i]) begin errors++; $display("FAIL %s_x: got %h want %h", nm[i], o.x, wx[i]); end
            if (o.y !== 32'h0) begin errors++; $display("FAIL %s_y: got %h want 0", nm[i], o.y); end
            if (o.z !== v[i].z) begin errors++; $display("FAIL %s_z: got %h want %h", nm[i], o.z, v[i].z); end
            if (o.clip !== wclip[i]) begin errors++; $display("FAIL %s_clip: got %b want %b", nm[i], o.clip, wclip[i]); end
            if (o.ovf !== wovf[i]) begin errors++; $display("FAIL %s_ovf: got %b want %b", nm[i], o.ovf, wovf[i]); end
            if (o.lat - t != wlat[i]) begin errors++; $display("FAIL %s_latency: got %0d want %0d", nm[i], o.lat - t, wlat[i]); end
        end
    endtask

    task automatic test_backpressure();
        vtx_t v [6];
        res_t e [6];
        res_t o;
        int   t;
        logic [31:0] head_x;
        for (int i = 0; i < 6; i++) begin
            v[i] = mk($urandom_range(0, 32'h000F_FFFF), $urandom_range(0, 32'h000F_FFFF),
                      32'h0004_0000, 1, 32'h0000_8000 + 32'($urandom_range(0, 32'hFFFF)), 32'h100,
                      $urandom_range(0, 32'h00FF_FFFF), $urandom_range(0, 32'h00FF_FFFF));
            e[i] = model(v[i]);
        end
        bus.out_ready = 1'b0;
        for (int i = 0; i < 5; i++) send(v[i], t);
        repeat (8) @(posedge clk);
        #1;
        head_x = bus.out_x;
        repeat (3) @(posedge clk);
        #1;
        checks += 4;
        if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready: got %b want 0", bus.in_ready); end
        if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL bp_out_valid: got %b want 1", bus.out_valid); end
        if (head_x !== e[0].x) begin errors++; $display("FAIL bp_head: got %h want %h", head_x, e[0].x); end
        if (bus.out_x !== head_x) begin errors++; $display("FAIL bp_stable: got %h want %h", bus.out_x, head_x); end
        fork
            send(v[5], t);
            begin
                bus.out_ready = 1'b1;
                for (int i = 0; i < 6; i++) begin
                    wait_out(o);
                    checks += 3;
                    if (o.x !== e[i].x) begin errors++; $display("FAIL bp_order_x[%0d]: got %h want %h", i, o.x, e[i].x); end
                    if (o.y !== e[i].y) begin errors++; $display("FAIL bp_order_y[%0d]: got %h want %h", i, o.y, e[i].y); end
                    if (o.color !== e[i].color) begin errors++; $display("FAIL bp_order_color[%0d]: got %h want %h", i, o.color, e[i].color); end
                end
            end
        join
    endtask

    task automatic test_reset_mid_div();
        vtx_t v;
        res_t e, o;
        int   t;
        v = mk(32'h0002_0000, 32'hFFFD_0000, 32'h0004_0000, 0, 32'h0001_0000, 32'h100, 32'h10, 32'h20);
        send(v, t);
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        checks += 4;
        if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL middiv_valid: got %b want 0", bus.out_valid); end
        if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL middiv_ready: got %b want 1", bus.in_ready); end
        if (bus.busy !== 1'b0) begin errors++; $display("FAIL middiv_busy: got %b want 0", bus.busy); end
        if (bus.out_x !== 32'h0) begin errors++; $display("FAIL middiv_out_x: got %h want 0", bus.out_x); end
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        v = mk(32'h0006_0000, 32'h0001_0000, 32'hFFFE_0000, 0, 32'h0001_0000, 32'h100, 0, 0);
        e = model(v);
        send(v, t);
        wait_out(o);
        checks += 3;
        if (o.x !== e.x) begin errors++; $display("FAIL after_reset_x: got %h want %h", o.x, e.x); end
        if (o.y !== e.y) begin errors++; $display("FAIL after_reset_y: got %h want %h", o.y, e.y); end
        if (o.lat - t != 50) begin errors++; $display("FAIL after_reset_latency: got %0d want 50", o.lat - t); end
    endtask

    task automatic test_random();
        vtx_t v;
        res_t e, o;
        int   t;
        for (int i = 0; i < 24; i++) begin
            v.x = 32'($signed($urandom) >>> $urandom_range(0, 14));
            v.y = 32'($signed($urandom) >>> $urandom_range(0, 14));
            if ($urandom_range(0, 3) == 0) v.z = $urandom_range(0, 32'h1FF) * (($urandom_range(0, 1) == 1) ? -1 : 1);
            else v.z = 32'($signed($urandom) >>> $urandom_range(8, 16));
            v.focal = $urandom >> $urandom_range(0, 14);
            v.near_z = $urandom_range(0, 32'h100);
            v.mode = ($urandom_range(0, 3) == 0);
            v.cx = 32'($signed($urandom) >>> $urandom_range(4, 12));
            v.cy = 32'($signed($urandom) >>> $urandom_range(4, 12));
            v.color = 16'($urandom);
            e = model(v);
            send(v, t);
            wait_out(o);
            checks += 7;
            if (o.x !== e.x) begin errors++; $display("FAIL rand_x[%0d]: got %h want %h", i, o.x, e.x); end
            if (o.y !== e.y) begin errors++; $display("FAIL rand_y[%0d]: got %h want %h", i, o.y, e.y); end
            if (o.z !== e.z) begin errors++; $display("FAIL rand_z[%0d]: got %h want %h", i, o.z, e.z); end
            if (o.color !== e.color) begin errors++; $display("FAIL rand_color[%0d]: got %h want %h", i, o.color, e.color); end
            if (o.clip !== e.clip) begin errors++; $display("FAIL rand_clip[%0d]: got %b want %b", i, o.clip, e.clip); end
            if (o.ovf !== e.ovf) begin errors++; $display("FAIL rand_ovf[%0d]: got %b want %b", i, o.ovf, e.ovf); end
            if (o.lat - t != e.lat) begin errors++; $display("FAIL rand_latency[%0d]: got %0d want %0d", i, o.lat - t, e.lat); end
        end
    endtask

    initial begin
        bus.in_valid = 1'b0; bus.out_ready = 1'b1; bus.mode = 1'b0;
        bus.in_x = '0; bus.in_y = '0; bus.in_z = '0; bus.in_color = '0;
        bus.focal = '0; bus.near_z = '0; bus.cx = '0; bus.cy = '0;
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_mid_div();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
